div_clk_monitor: RTL and testbench

DIV_CLK_MONITOR -- requirements
Module: div_clk_monitor

---
 rtl/div_clk_monitor.sv | 166 ++++++++++++++++
 tb/tb_div_clk_monitor.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/div_clk_monitor.sv
// div_clk_monitor
//   Measures one period of a divided clock (clk_in) that is generated from clk.
//   After a start pulse the block waits for a rising edge of clk_in. It then
//   counts the clk cycles in which clk_in was sampled high and low, up to the
//   next rising edge. Results are latched and flagged with a one-cycle valid.
//   A watchdog aborts a measurement that sees no clk_in edge for 2^CNT_W-1
//   cycles. It flags err, which stays set until the next accepted start.
//
// Ports
//   clk       system clock (also the divider source clock)
//   rst       asynchronous active-high reset
//   clk_in    divided clock under test
//   start     one-cycle pulse arming a measurement (ignored while busy)
//   busy      measurement in progress
//   valid     one-cycle pulse, results updated
//   high_cnt  cycles sampled high
//   low_cnt   cycles sampled low
//   period    high_cnt + low_cnt, saturated to CNT_W bits
//   duty_ok   |high_cnt - low_cnt| <= 1
//   freq_ok   period == EXP_PERIOD
//   err       watchdog timeout, sticky until next start
//
// Build option
//   DIVMON_SYNC_EN  when defined, clk_in passes through a 2-flop synchronizer
//                   before sampling. Edges are seen 2 cycles later and the
//                   count values do not change.
module div_clk_monitor #(
  parameter int CNT_W      = 8,
  parameter int EXP_PERIOD = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_in,
  input  logic             start,
  output logic             busy,
  output logic             valid,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] low_cnt,
  output logic [CNT_W-1:0] period,
  output logic             duty_ok,
  output logic             freq_ok,
  output logic             err
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_RISE = 2'd1;
  localparam logic [1:0] MEAS_HIGH = 2'd2;
  localparam logic [1:0] MEAS_LOW  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  // The watchdog is about to reach CNT_MAX on this edge.
  localparam logic [CNT_W-1:0] WD_LAST = {{(CNT_W-1){1'b1}}, 1'b0};
  localparam logic [CNT_W-1:0] EXP_W   = EXP_PERIOD[CNT_W-1:0];

  logic             lvl, lvl_d;
  logic             rise, fall;
  logic [1:0]       state;
  logic [CNT_W-1:0] hcnt, lcnt, wd;
  logic [CNT_W:0]   sum;
  logic [CNT_W-1:0] per_sat, diff;
  logic             wd_expire;

  // clk_in sampling
`ifdef DIVMON_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b00;
      lvl    <= 1'b0;
      lvl_d  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], clk_in};
      lvl    <= sync_q[1];
      lvl_d  <= lvl;
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl   <= 1'b0;
      lvl_d <= 1'b0;
    end else begin
      lvl   <= clk_in;
      lvl_d <= lvl;
    end
  end
`endif

  assign rise = lvl & ~lvl_d;
  assign fall = ~lvl & lvl_d;
  assign busy = (state != IDLE);

  always_comb begin
    sum       = {1'b0, hcnt} + {1'b0, lcnt};
    per_sat   = sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
    diff      = (hcnt >= lcnt) ? (hcnt - lcnt) : (lcnt - hcnt);
    // Any clk_in edge restarts the watchdog, so it never expires on an edge.
    wd_expire = (state != IDLE) && !(rise || fall) && (wd == WD_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      hcnt     <= '0;
      lcnt     <= '0;
      wd       <= '0;
      valid    <= 1'b0;
      err      <= 1'b0;
      high_cnt <= '0;
      low_cnt  <= '0;
      period   <= '0;
      duty_ok  <= 1'b0;
      freq_ok  <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          state <= WAIT_RISE;
          err   <= 1'b0;
          hcnt  <= '0;
          lcnt  <= '0;
          wd    <= '0;
        end
      end else begin
        wd <= (rise || fall) ? '0 : wd + ONE;
        if (wd_expire) begin
          state    <= IDLE;
          err      <= 1'b1;
          valid    <= 1'b1;
          high_cnt <= '0;
          low_cnt  <= '0;
          period   <= '0;
          duty_ok  <= 1'b0;
          freq_ok  <= 1'b0;
        end else if (state == WAIT_RISE) begin
          if (rise) begin
            state <= MEAS_HIGH;
            hcnt  <= ONE;            // the rise cycle itself is high
          end
        end else if (state == MEAS_HIGH) begin
          if (fall) begin
            state <= MEAS_LOW;
            lcnt  <= ONE;            // the fall cycle itself is low
          end else if (hcnt != CNT_MAX) begin
            hcnt <= hcnt + ONE;
          end
        end else begin               // MEAS_LOW
          if (rise) begin
            // The second rise is not counted as low; it closes the period.
            state    <= IDLE;
            valid    <= 1'b1;
            high_cnt <= hcnt;
            low_cnt  <= lcnt;
            period   <= per_sat;
            duty_ok  <= (diff <= ONE);
            freq_ok  <= (per_sat == EXP_W);
          end else if (lcnt != CNT_MAX) begin
            lcnt <= lcnt + ONE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_div_clk_monitor.sv
module tb_div_clk_monitor;

  localparam int CNT_W      = 8;
  localparam int EXP_PERIOD = 5;
  localparam int MAXV       = (1 << CNT_W) - 1;
`ifdef DIVMON_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic             clk, rst, clk_in, start;
  logic             busy, valid, duty_ok, freq_ok, err;
  logic [CNT_W-1:0] high_cnt, low_cnt, period;

  div_clk_monitor #(.CNT_W(CNT_W), .EXP_PERIOD(EXP_PERIOD)) dut (
    .clk(clk), .rst(rst), .clk_in(clk_in), .start(start),
    .busy(busy), .valid(valid), .high_cnt(high_cnt), .low_cnt(low_cnt),
    .period(period), .duty_ok(duty_ok), .freq_ok(freq_ok), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int     hc, lc, per;
    bit     duty, freq, er;
    longint cyc;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input longint act, input longint req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference: one full period of h high and l low samples.
  function automatic exp_t model(input int h, input int l, input longint c);
    exp_t e;
    int   d;
    e.hc   = (h > MAXV) ? MAXV : h;
    e.lc   = (l > MAXV) ? MAXV : l;
    e.per  = (e.hc + e.lc > MAXV) ? MAXV : e.hc + e.lc;
    d      = (e.hc > e.lc) ? e.hc - e.lc : e.lc - e.hc;
    e.duty = (d <= 1);
    e.freq = (e.per == EXP_PERIOD);
    e.er   = 1'b0;
    e.cyc  = c;
    return e;
  endfunction

  // Monitor / scoreboard
  exp_t mon_e;
  bit   vld_prev = 1'b0;
  always @(negedge clk) begin
    if (valid) begin
      chk("valid_one_cycle", vld_prev, 0);
      if (q.size() == 0) chk("unexpected_valid", 1, 0);
      else begin
        mon_e = q.pop_front();
        chk("high_cnt", high_cnt, mon_e.hc);
        chk("low_cnt",  low_cnt,  mon_e.lc);
        chk("period",   period,   mon_e.per);
        chk("duty_ok",  duty_ok,  mon_e.duty);
        chk("freq_ok",  freq_ok,  mon_e.freq);
        chk("err",      err,      mon_e.er);
        chk("busy_at_valid", busy, 0);
        chk("valid_cycle", cyc, mon_e.cyc);
      end
    end
    vld_prev = valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (q.size() != 0) begin
      chk("result_wait_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  task automatic run_meas(input int h, input int l, input bit repulse);
    exp_t e;
    int   d;
    clk_in = 1'b0;
    repeat (5) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("err_cleared", err, 0);
    d = $urandom_range(0, 3);
    repeat (d) tick();
    for (int i = 0; i < h; i++) begin
      clk_in = 1'b1;
      if (repulse && i == h / 2) start = 1'b1;
      tick();
      start = 1'b0;
    end
    clk_in = 1'b0;
    repeat (l) tick();
    clk_in = 1'b1;
    e = model(h, l, cyc + LAT);
    q.push_back(e);
    repeat (3) tick();
    clk_in = 1'b0;
    wait_done(20);
    repeat (2) tick();
    chk("hold_period", period, e.per);
    chk("hold_high_cnt", high_cnt, e.hc);
  endtask

  task automatic run_timeout(input bit level);
    exp_t e;
    clk_in = level;
    repeat (6) tick();
    e.hc = 0; e.lc = 0; e.per = 0;
    e.duty = 1'b0; e.freq = 1'b0; e.er = 1'b1;
    e.cyc = cyc + MAXV + 1;
    q.push_back(e);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(MAXV + 20);
    repeat (5) tick();
    chk("err_sticky", err, 1);
    chk("busy_after_timeout", busy, 0);
    clk_in = 1'b0;
  endtask

  task automatic run_rst_mid();
    clk_in = 1'b0;
    repeat (5) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    clk_in = 1'b1;
    repeat (5) tick();
    clk_in = 1'b0;
    repeat (2) tick();
    #2 rst = 1'b1;
    #1 chk("rst_mid_outputs",
           {busy, valid, err, duty_ok, freq_ok, high_cnt, low_cnt, period}, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("idle_after_rst", busy, 0);
    clk_in = 1'b1;
    repeat (6) tick();
    chk("no_result_after_rst", {busy, high_cnt, period}, 0);
    clk_in = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    clk_in = 1'b0;
    repeat (4) begin
      #4 chk("rst_outputs",
             {busy, valid, err, duty_ok, freq_ok, high_cnt, low_cnt, period}, 0);
      #1 clk_in = ~clk_in;
    end
    #1 rst = 1'b0;
    clk_in = 1'b0;

    run_meas(3, 2, 1'b0);
    run_meas(2, 3, 1'b0);
    run_meas(4, 1, 1'b0);
    run_meas(1, 1, 1'b0);
    run_timeout(1'b0);
    run_meas(3, 2, 1'b1);
    run_timeout(1'b1);
    run_meas(255, 3, 1'b0);
    run_meas(200, 200, 1'b0);
    run_meas(1, 254, 1'b0);
    run_rst_mid();
    for (int k = 0; k < 20; k++)
      run_meas($urandom_range(1, 40), $urandom_range(1, 40), 1'($urandom_range(0, 1)));

    chk("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
